// File: rtl/ring_boundary_buf_pkg.sv
// rtl/ring_boundary_buf_pkg.sv - shared constants, types and packing helper for the ring boundary buffer
package ring_boundary_buf_pkg;

    localparam int RBB_DEFAULT_WIDTH    = 128;
    localparam int RBB_DEFAULT_CHANNELS = 2;
    localparam int RBB_DEFAULT_DEPTH    = 4;

    // Encoded as {push, pop} so the handshake pair can be cast straight in.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int lane_lsb(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

endpackage

// File: rtl/ring_boundary_fifo.sv
// rtl/ring_boundary_fifo.sv - single-channel registered FIFO used at a ring boundary
module ring_boundary_fifo
    import ring_boundary_buf_pkg::*;
#(
    parameter int WIDTH = RBB_DEFAULT_WIDTH,
    parameter int DEPTH = RBB_DEFAULT_DEPTH,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    occupancy
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    fifo_op_e         op;

    // Handshake flags depend only on the registered count, never on inputs.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign occupancy = count;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    assign op   = fifo_op_e'({push, pop});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/ring_boundary_buf.sv
// rtl/ring_boundary_buf.sv - bank of independent per-channel boundary FIFOs
module ring_boundary_buf
    import ring_boundary_buf_pkg::*;
#(
    parameter int WIDTH    = RBB_DEFAULT_WIDTH,
    parameter int CHANNELS = RBB_DEFAULT_CHANNELS,
    parameter int DEPTH    = RBB_DEFAULT_DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*CW-1:0]    occupancy
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        ring_boundary_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid[c]),
            .in_data   (in_data[lane_lsb(c, WIDTH) +: WIDTH]),
            .in_ready  (in_ready[c]),
            .out_valid (out_valid[c]),
            .out_data  (out_data[lane_lsb(c, WIDTH) +: WIDTH]),
            .out_ready (out_ready[c]),
            .occupancy (occupancy[lane_lsb(c, CW) +: CW])
        );
    end

endmodule

// File: tb/tb_ring_boundary_buf.sv
// tb/tb_ring_boundary_buf.sv - directed self-checking bench for ring_boundary_buf
module tb_ring_boundary_buf;

    localparam int WIDTH    = 128;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 4;
    localparam int CW       = 3;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS*CW-1:0]    occupancy;

    int passed = 0;
    int total  = 0;

    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] vec;

    ring_boundary_buf #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        #3;
        check("rst_occ",   WIDTH'(occupancy), '0);
        check("rst_ovalid", WIDTH'(out_valid), '0);
        check("rst_iready", WIDTH'(in_ready),  WIDTH'(2'b11));
        @(negedge clk);
        rst = 1'b1;

        // single push on channel 0, first edge with reset high
        vec = 128'h0123456789abcdef0123456789abcdef;
        in_valid = 2'b01;
        in_data[127:0] = vec;
        step();
        in_valid = '0;
        check("push1_ovalid", WIDTH'(out_valid), WIDTH'(2'b01));
        check("push1_data",   out_data[127:0], vec);
        check("push1_occ0",   WIDTH'(occupancy[2:0]), WIDTH'(1));
        check("push1_occ1",   WIDTH'(occupancy[5:3]), WIDTH'(0));
        check("push1_iready", WIDTH'(in_ready), WIDTH'(2'b11));
        out_ready = 2'b01;
        step();
        out_ready = '0;
        check("drain_occ0", WIDTH'(occupancy[2:0]), WIDTH'(0));

        // fill 1..4, hold a fifth offer, then drain in order
        for (int i = 1; i <= 4; i++) begin
            in_valid = 2'b01;
            in_data[127:0] = WIDTH'(i);
            step();
        end
        in_data[127:0] = WIDTH'(5);
        check("full_iready", WIDTH'(in_ready[0]), WIDTH'(0));
        check("full_occ0",   WIDTH'(occupancy[2:0]), WIDTH'(4));
        step();
        check("held_occ0",   WIDTH'(occupancy[2:0]), WIDTH'(4));
        check("held_data1",  out_data[127:0], WIDTH'(1));
        out_ready = 2'b01;
        step();
        check("pop1_occ0",   WIDTH'(occupancy[2:0]), WIDTH'(3));
        check("seq_data2",   out_data[127:0], WIDTH'(2));
        step();
        in_valid = '0;
        check("both_occ0",   WIDTH'(occupancy[2:0]), WIDTH'(3));
        check("seq_data3",   out_data[127:0], WIDTH'(3));
        step();
        check("seq_data4",   out_data[127:0], WIDTH'(4));
        step();
        check("seq_data5",   out_data[127:0], WIDTH'(5));
        check("seq_occ1",    WIDTH'(occupancy[2:0]), WIDTH'(1));
        step();
        out_ready = '0;
        check("seq_empty",   WIDTH'(out_valid[0]), WIDTH'(0));

        // full channel with simultaneous offer and accept
        for (int i = 0; i < 4; i++) begin
            in_valid = 2'b01;
            in_data[127:0] = WIDTH'(16 + i);
            step();
        end
        in_data[127:0] = WIDTH'(20);
        out_ready = 2'b01;
        step();
        out_ready = '0;
        check("fullpop_occ0",   WIDTH'(occupancy[2:0]), WIDTH'(3));
        check("fullpop_data",   out_data[127:0], WIDTH'(17));
        check("fullpop_iready", WIDTH'(in_ready[0]), WIDTH'(1));
        step();
        in_valid = '0;
        check("refill_occ0", WIDTH'(occupancy[2:0]), WIDTH'(4));

        // channel 1: pointer wrap with a scoreboard; channel 0 must stay put
        in_valid = 2'b10;
        in_data[255:128] = WIDTH'(160);
        sb.push_back(WIDTH'(160));
        step();
        out_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            in_data[255:128] = WIDTH'(176 + i);
            step();
            void'(sb.pop_front());
            sb.push_back(WIDTH'(176 + i));
            check("wrap_data", out_data[255:128], sb[0]);
            check("wrap_occ1", WIDTH'(occupancy[5:3]), WIDTH'(1));
        end
        in_valid  = '0;
        out_ready = '0;
        check("indep_occ0", WIDTH'(occupancy[2:0]), WIDTH'(4));
        check("indep_data", out_data[127:0], WIDTH'(17));

        // occupancy 3, then flush while pushing
        out_ready = 2'b01;
        step();
        out_ready = '0;
        check("pre_flush_occ0", WIDTH'(occupancy[2:0]), WIDTH'(3));
        flush = 1'b1;
        in_valid = 2'b01;
        in_data[127:0] = WIDTH'(255);
        step();
        flush = 1'b0;
        in_valid = '0;
        check("flush_occ",    WIDTH'(occupancy), WIDTH'(0));
        check("flush_ovalid", WIDTH'(out_valid), WIDTH'(0));
        check("flush_iready", WIDTH'(in_ready), WIDTH'(2'b11));

        // restart traffic then pull reset low between edges
        in_valid = 2'b11;
        in_data[127:0]   = WIDTH'(48);
        in_data[255:128] = WIDTH'(64);
        step();
        check("post_flush_occ", WIDTH'(occupancy), WIDTH'(6'b001_001));
        check("post_flush_d0",  out_data[127:0], WIDTH'(48));
        #2;
        rst = 1'b0;
        #1;
        check("async_occ",    WIDTH'(occupancy), WIDTH'(0));
        check("async_ovalid", WIDTH'(out_valid), WIDTH'(0));
        check("async_iready", WIDTH'(in_ready), WIDTH'(2'b11));
        in_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 2'b10;
        in_data[255:128] = WIDTH'(99);
        step();
        in_valid = '0;
        check("rerun_occ",  WIDTH'(occupancy), WIDTH'(6'b001_000));
        check("rerun_data", out_data[255:128], WIDTH'(99));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ring_boundary_buf.md
RING_BOUNDARY_BUF -- requirements
Module: ring_boundary_buf

Interface
REQ-001 Parameter WIDTH, default 128: flit width in bits per channel.
REQ-002 Parameter CHANNELS, default 2: number of independent boundary channels.
REQ-003 Parameter DEPTH, default 4: entries per channel FIFO; SHALL be a power of two, minimum 2.
REQ-004 Derived constant CW = clog2(DEPTH+1): occupancy count width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  synchronous clear of all channels.
REQ-008 in_valid  in  CHANNELS  per-channel flit offered.
REQ-009 in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 in_ready  out  CHANNELS  per-channel space available.
REQ-011 out_valid  out  CHANNELS  per-channel flit presented.
REQ-012 out_data  out  CHANNELS*WIDTH  same packing as in_data.
REQ-013 out_ready  in  CHANNELS  per-channel downstream accept.
REQ-014 occupancy  out  CHANNELS*CW  per-channel entry count, channel c at [c*CW +: CW].

Function
REQ-015 Channels SHALL be fully independent; activity on one SHALL NOT affect another.
REQ-016 Push occurs on an edge where in_valid[c] and in_ready[c] are both 1; pop occurs where out_valid[c] and out_ready[c] are both 1.
REQ-017 in_ready[c] SHALL equal (occupancy[c] != DEPTH), a function of registered state only.
REQ-018 out_valid[c] SHALL equal (occupancy[c] != 0); out_data[c] SHALL be the oldest stored flit, taken from a register, with no combinational path from in_data.
REQ-019 Minimum latency SHALL be one cycle: a flit pushed into an empty channel at edge k is valid after edge k.
REQ-020 Order SHALL be FIFO; flits SHALL never be dropped, duplicated or reordered.
REQ-021 Simultaneous push and pop in one cycle SHALL leave occupancy unchanged; when full, push is blocked by in_ready=0 even if a pop occurs that cycle.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 occupancy SHALL increment on push-only, decrement on pop-only, and saturate at neither end, because handshakes prevent overflow and underflow.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 flush=1 at an edge SHALL zero all pointers and occupancies; a push or pop in that same cycle SHALL be ignored.
REQ-026 Storage contents need not be cleared by reset or flush; out_data is don't-care while out_valid=0.

Reset
REQ-027 rst low SHALL immediately force occupancy=0, out_valid=0, in_ready=all ones, and pointers=0, independent of clk.
REQ-028 Reset asserted mid-transfer SHALL discard all stored flits; there is no recovery of state.
REQ-029 Reset deassertion SHALL be synchronised externally; the first push is accepted on the first edge with rst high.

Structure
REQ-030 WIDTH default, the control flit width macro, and the packing helper constants SHALL live in the shared defines include used by the hring routers.
REQ-031 One sub-module, ring_boundary_fifo (single channel, parameters WIDTH and DEPTH), SHALL be instantiated CHANNELS times via generate.

Verification
REQ-032 Reset with all inputs 0 -> occupancy=0, out_valid=0, in_ready=2'b11.
REQ-033 Channel 0: push 128'h0123...cdef with out_ready=0 -> next cycle out_valid[0]=1, out_data[0]=pushed value, occupancy[0]=1; channel 1 unchanged.
REQ-034 Channel 0: push 4 flits 1..4 with out_ready=0 -> in_ready[0]=0, occupancy[0]=4; a 5th offer is held; set out_ready=1 -> output sequence 1,2,3,4,5.
REQ-035 Full channel with simultaneous in_valid and out_ready -> pop accepted, push blocked, occupancy=3; next cycle push accepted, occupancy=4.
REQ-036 Run 10 push/pop pairs through DEPTH=4 to wrap the pointers twice -> data matches a scoreboard, occupancy stays 1.
REQ-037 Occupancy=3, then flush=1 while pushing -> occupancy=0, out_valid=0; then pull rst low mid-stream -> outputs clear immediately, without waiting for a clk edge.
